vid_out_16b_axis: RTL

- Converts a 16-bit AXI4-Stream video stream (tuser = SOF, tlast = EOL) into parallel video with DE/blank/sync.
- Timing comes from an external timing generator (vtg_*) on the same clock.
- Sits at the HDMI output end of the pipeline, after VDMA/stream processing, as the mirror of the video-in-to-AXIS bridge.
- Uses a small synchronous pixel FIFO to absorb stream burstiness and locks stream SOF to timing start-of-frame.

---
 rtl/vid_out_16b_axis.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/vid_out_16b_axis.sv
// AXI4-Stream (tuser = SOF, tlast = EOL) to parallel video bridge.
// A small pixel FIFO absorbs stream bursts; pops are paced by the external timing generator.
module vid_out_16b_axis #(
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 32
) (
   input  logic                    vclk,
   input  logic                    reset,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic                    s_axis_tuser,
   input  logic                    s_axis_tlast,
   input  logic                    vtg_vblank,
   input  logic                    vtg_vsync,
   input  logic                    vtg_hblank,
   input  logic                    vtg_hsync,
   input  logic                    vtg_active_video,
   output logic                    vtg_ce,
   output logic                    vid_vblank,
   output logic                    vid_vsync,
   output logic                    vid_hblank,
   output logic                    vid_hsync,
   output logic                    vid_active_video,
   output logic [DATA_WIDTH-1:0]   vid_data,
   output logic                    locked,
   output logic                    underflow,
   output logic                    overflow,
   output logic                    align_err
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = DATA_WIDTH + 2;
   localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);

   typedef enum logic [1:0] {
      WAIT_SOF   = 2'd0,
      WAIT_FRAME = 2'd1,
      LOCKED     = 2'd2
   } state_t;

   state_t                state_r;
   logic                  run_r;
   logic [EW-1:0]         mem_r [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr_r, rd_ptr_r;
   logic [AW:0]           count_r;
   logic                  seen_vblank_r, vb_since_act_r, prev_active_r, last_tlast_r;
   logic                  vblank_r, vsync_r, hblank_r, hsync_r, active_r;
   logic [DATA_WIDTH-1:0] vid_data_r;
   logic                  locked_r, underflow_r, overflow_r, align_err_r;

   logic                  full_s, empty_s, tready_s, wr_req_s, wr_s, rd_s, ovf_s, flush_s;
   logic                  underflow_s, align_err_s, tlast_err_s, tuser_err_s, first_px_s;
   logic [EW-1:0]         head_s;
   logic                  unused_tkeep_s;

   assign unused_tkeep_s = ^s_axis_tkeep;

   // FIFO status, handshake and error decode for the current cycle
   always_comb begin
      full_s      = (count_r == DEPTH_CNT);
      empty_s     = (count_r == {(AW+1){1'b0}});
      head_s      = mem_r[rd_ptr_r];
      first_px_s  = vtg_active_video & vb_since_act_r;
      tready_s    = 1'b0;
      rd_s        = 1'b0;
      tlast_err_s = 1'b0;
      case (state_r)
         WAIT_SOF:           tready_s = run_r;
         WAIT_FRAME, LOCKED: tready_s = run_r & ~full_s;
         default:            tready_s = 1'b0;
      endcase
      underflow_s = (state_r == LOCKED) & vtg_active_video & empty_s;
      // tlast is checked one cycle late against where the line really ended
      if (vtg_active_video) begin
         tlast_err_s = prev_active_r & last_tlast_r;
      end else begin
         tlast_err_s = prev_active_r & ~last_tlast_r;
      end
      tuser_err_s = vtg_active_video & ~empty_s & head_s[EW-1] & ~first_px_s;
      align_err_s = (state_r == LOCKED) & ~underflow_s & (tlast_err_s | tuser_err_s);
      flush_s     = underflow_s | align_err_s;
      case (state_r)
         WAIT_FRAME: rd_s = vtg_active_video & seen_vblank_r & ~empty_s;
         LOCKED:     rd_s = vtg_active_video & ~empty_s & ~align_err_s;
         default:    rd_s = 1'b0;
      endcase
      wr_req_s = s_axis_tvalid & tready_s & ((state_r != WAIT_SOF) | s_axis_tuser);
      ovf_s    = wr_req_s & full_s & ~rd_s;
      wr_s     = wr_req_s & ~ovf_s & ~flush_s;
   end

   // FIFO storage, no reset needed: pointers define validity
   always_ff @(posedge vclk) begin
      if (wr_s) begin
         mem_r[wr_ptr_r] <= {s_axis_tuser, s_axis_tlast, s_axis_tdata};
      end
   end

   // FIFO pointers and occupancy; any error flushes so resync starts clean
   always_ff @(posedge vclk) begin
      if (reset || flush_s) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else begin
         if (wr_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (rd_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
         case ({wr_s, rd_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Alignment FSM with the registered video output stage
   always_ff @(posedge vclk) begin
      if (reset) begin
         state_r        <= WAIT_SOF;
         run_r          <= 1'b0;
         seen_vblank_r  <= 1'b0;
         vb_since_act_r <= 1'b0;
         prev_active_r  <= 1'b0;
         last_tlast_r   <= 1'b0;
         vblank_r       <= 1'b0;
         vsync_r        <= 1'b0;
         hblank_r       <= 1'b0;
         hsync_r        <= 1'b0;
         active_r       <= 1'b0;
         vid_data_r     <= {DATA_WIDTH{1'b0}};
         locked_r       <= 1'b0;
         underflow_r    <= 1'b0;
         overflow_r     <= 1'b0;
         align_err_r    <= 1'b0;
      end else begin
         run_r          <= 1'b1;
         vblank_r       <= vtg_vblank;
         vsync_r        <= vtg_vsync;
         hblank_r       <= vtg_hblank;
         hsync_r        <= vtg_hsync;
         active_r       <= vtg_active_video;
         prev_active_r  <= vtg_active_video;
         vb_since_act_r <= vtg_vblank | (vb_since_act_r & ~vtg_active_video);
         underflow_r    <= underflow_s;
         align_err_r    <= align_err_s;
         overflow_r     <= ovf_s;
         vid_data_r     <= rd_s ? head_s[DATA_WIDTH-1:0] : {DATA_WIDTH{1'b0}};
         if (rd_s) last_tlast_r <= head_s[DATA_WIDTH];
         case (state_r)
            WAIT_SOF: begin
               seen_vblank_r <= 1'b0;
               locked_r      <= 1'b0;
               if (s_axis_tvalid && s_axis_tuser) state_r <= WAIT_FRAME;
            end
            WAIT_FRAME: begin
               if (rd_s) begin
                  state_r  <= LOCKED;
                  locked_r <= 1'b1;
               end else begin
                  seen_vblank_r <= seen_vblank_r | vtg_vblank;
                  locked_r      <= 1'b0;
               end
            end
            LOCKED: begin
               if (flush_s) begin
                  state_r  <= WAIT_SOF;
                  locked_r <= 1'b0;
               end else begin
                  locked_r <= 1'b1;
               end
            end
            default: begin
               state_r  <= WAIT_SOF;
               locked_r <= 1'b0;
            end
         endcase
      end
   end

   assign s_axis_tready    = tready_s;
   assign vtg_ce           = run_r;
   assign vid_vblank       = vblank_r;
   assign vid_vsync        = vsync_r;
   assign vid_hblank       = hblank_r;
   assign vid_hsync        = hsync_r;
   assign vid_active_video = active_r;
   assign vid_data         = vid_data_r;
   assign locked           = locked_r;
   assign underflow        = underflow_r;
   assign overflow         = overflow_r;
   assign align_err        = align_err_r;
endmodule
